shift_operand_stage: RTL

- Buffered stage directly upstream of the combinational shifter in the multi-cycle datapath.
- Accepts the ARM-style shift field, the Rm value and the Rs value with a valid/ready handshake.
- Resolves immediate vs register shift amounts and the boundary encodings (#0 meaning #32, amounts >= 32) into the shifter's inputs: operand, 5-bit shamt and 2-bit control.
- Holds up to two entries in a skid buffer so the decode FSM can issue while the shifter/ALU side stalls.

---
 rtl/shift_operand_stage_pkg.sv | 25 ++
 rtl/shift_operand_stage_decode.sv | 61 ++++++
 rtl/shift_operand_stage.sv | 84 ++++++++
 3 files changed

// File: rtl/shift_operand_stage_pkg.sv
// rtl/shift_operand_stage_pkg.sv - shared constants and entry type for the shift operand stage
package shift_operand_stage_pkg;

    localparam int W_DATA  = 32;
    localparam int W_SHAMT = 5;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // shift_field layout: {imm shamt[7:3], sh[2:1], reg_sel[0]}
    localparam int SF_REG_BIT = 0;
    localparam int SF_SH_LSB  = 1;
    localparam int SF_SH_MSB  = 2;
    localparam int SF_AMT_LSB = 3;
    localparam int SF_AMT_MSB = 7;

    typedef struct packed {
        logic [W_DATA-1:0]  operand;
        logic [W_SHAMT-1:0] shamt;
        logic [1:0]         control;
    } shift_op_t;

endpackage

// File: rtl/shift_operand_stage_decode.sv
// rtl/shift_operand_stage_decode.sv - resolves the shift field into shifter operand, amount and control
module shift_field_decode
    import shift_operand_stage_pkg::*;
#(
    parameter int W    = 32,
    parameter int RS_W = 8
) (
    input  logic [7:0]         shift_field,
    input  logic [W-1:0]       rm_data,
    input  logic [RS_W-1:0]    rs_data,
    output logic [W-1:0]       inp_shifter,
    output logic [W_SHAMT-1:0] shamt,
    output logic [1:0]         control
);

    logic                 reg_sel;
    logic [1:0]           sh;
    logic [W_SHAMT-1:0]   imm_amt;
    logic                 rs_zero;
    logic                 rs_big;

    assign reg_sel = shift_field[SF_REG_BIT];
    assign sh      = shift_field[SF_SH_MSB:SF_SH_LSB];
    assign imm_amt = shift_field[SF_AMT_MSB:SF_AMT_LSB];
    assign rs_zero = (rs_data == '0);
    assign rs_big  = (rs_data > RS_W'(31));

    always_comb begin
        inp_shifter = rm_data;
        shamt       = imm_amt;
        control     = sh;
        if (!reg_sel) begin
            // #0 encodes #32 for LSR/ASR; ROR #0 (RRX) degrades to a plain pass-through
            if (imm_amt == '0) begin
                if (sh == SH_LSR) begin
                    inp_shifter = '0;
                    control     = SH_LSL;
                end else if (sh == SH_ASR) begin
                    shamt = 5'd31;
                end
            end
        end else begin
            shamt = rs_data[W_SHAMT-1:0];
            if (rs_zero) begin
                shamt   = '0;
                control = SH_LSL;
            end else if (rs_big) begin
                case (sh)
                    SH_LSL, SH_LSR: begin
                        inp_shifter = '0;
                        shamt       = '0;
                        control     = SH_LSL;
                    end
                    SH_ASR:  shamt = 5'd31;
                    default: shamt = rs_data[W_SHAMT-1:0];
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_operand_stage.sv
// rtl/shift_operand_stage.sv - two-entry skid buffer feeding resolved operands to the shifter
module shift_operand_stage
    import shift_operand_stage_pkg::*;
#(
    parameter int W    = 32,
    parameter int RS_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         shift_field,
    input  logic [W-1:0]       rm_data,
    input  logic [RS_W-1:0]    rs_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       inp_shifter,
    output logic [W_SHAMT-1:0] shamt,
    output logic [1:0]         control
);

    shift_op_t   dec;
    shift_op_t   slot0;
    shift_op_t   slot1;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        push;
    logic        pop;

    shift_field_decode #(
        .W    (W),
        .RS_W (RS_W)
    ) u_decode (
        .shift_field (shift_field),
        .rm_data     (rm_data),
        .rs_data     (rs_data),
        .inp_shifter (dec.operand),
        .shamt       (dec.shamt),
        .control     (dec.control)
    );

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // slot0 is always the head; slot1 shifts down on a pop
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 2'd0;
            in_ready <= 1'b1;
            slot0    <= '0;
            slot1    <= '0;
        end else begin
            count    <= count_next;
            in_ready <= (count_next < 2'd2);
            if (push && pop) begin
                slot0 <= dec;
            end else if (push) begin
                if (count == 2'd0) begin
                    slot0 <= dec;
                end else begin
                    slot1 <= dec;
                end
            end else if (pop) begin
                slot0 <= slot1;
                slot1 <= '0;
            end
        end
    end

    assign out_valid   = (count != 2'd0);
    assign inp_shifter = out_valid ? slot0.operand : '0;
    assign shamt       = out_valid ? slot0.shamt   : '0;
    assign control     = out_valid ? slot0.control : '0;

endmodule
